// File: rtl/atm_transaction_ctrl_pkg.sv
// ============================================================================
// Module      : atm_pkg
// Description : Shared definitions for the ATM transaction controller:
//               operation codes, result codes and the session state encoding.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package atm_pkg;

    // Operation codes presented with op_valid
    localparam logic [1:0] c_op_inquiry  = 2'b00;
    localparam logic [1:0] c_op_withdraw = 2'b01;
    localparam logic [1:0] c_op_deposit  = 2'b10;
    localparam logic [1:0] c_op_exit     = 2'b11;

    // Result codes qualified by result_valid
    localparam logic [2:0] c_res_ok       = 3'd0;
    localparam logic [2:0] c_res_bad_pin  = 3'd1;
    localparam logic [2:0] c_res_no_funds = 3'd2;
    localparam logic [2:0] c_res_limit    = 3'd3;
    localparam logic [2:0] c_res_overflow = 3'd4;
    localparam logic [2:0] c_res_timeout  = 3'd5;
    localparam logic [2:0] c_res_retained = 3'd6;

    // Session state encoding
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PIN_WAIT  = 3'd1,
        S_PIN_CHECK = 3'd2,
        S_MENU      = 3'd3,
        S_EXEC      = 3'd4,
        S_COMMIT    = 3'd5,
        S_EJECT     = 3'd6
    } state_t;

    // A session is live from PIN entry until the card is ejected
    function automatic logic is_session_state(input state_t st);
        return (st == S_PIN_WAIT) || (st == S_PIN_CHECK) || (st == S_MENU) ||
               (st == S_EXEC)     || (st == S_COMMIT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/atm_transaction_ctrl_if.sv
// ============================================================================
// Module      : atm_transaction_ctrl_if
// Description : Bus between the card-handling stage (master) and the
//               transaction controller (slave): PIN/op handshake, balance
//               datapath and session status.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface atm_transaction_ctrl_if #(
    parameter int BALANCE_WIDTH = 20
);
    logic                     card_inserted;
    logic                     pin_valid;
    logic                     op_valid;
    logic                     op_ready;
    logic [1:0]               op_code;
    logic [BALANCE_WIDTH-1:0] amount;
    logic [BALANCE_WIDTH-1:0] balance;
    logic                     wrong_psw;
    logic [BALANCE_WIDTH-1:0] updated_balance;
    logic                     op_done;
    logic [BALANCE_WIDTH-1:0] shown_balance;
    logic                     result_valid;
    logic [2:0]               result_code;
    logic                     session_active;
    logic                     card_retained;

    // Upstream card stage / user side
    modport master (
        output card_inserted, pin_valid, op_valid, op_code, amount, balance, wrong_psw,
        input  op_ready, updated_balance, op_done, shown_balance,
               result_valid, result_code, session_active, card_retained
    );

    // Transaction controller side
    modport slave (
        input  card_inserted, pin_valid, op_valid, op_code, amount, balance, wrong_psw,
        output op_ready, updated_balance, op_done, shown_balance,
               result_valid, result_code, session_active, card_retained
    );

endinterface

`default_nettype wire

// File: rtl/atm_transaction_ctrl_session_timer.sv
// ============================================================================
// Module      : atm_session_timer
// Description : Idle timer for the PIN-wait and menu states. Counts while
//               enabled, restarts on clear, and flags expiry combinationally
//               in the cycle the count reaches TIMEOUT_CYCLES-1.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module atm_session_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  i_clear,
    input  wire  i_enable,
    output logic o_expired
);

    localparam int                 c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] r_count;

    // Idle counter: restart on clear, hold at the terminal value
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_last)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_enable && (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/atm_transaction_ctrl.sv
// ============================================================================
// Module      : atm_transaction_ctrl
// Description : Session/transaction controller downstream of the card stage.
//               Runs PIN retry and the operation menu, evaluates inquiry,
//               withdraw and deposit requests and commits the new balance
//               upstream with a one-cycle op_done pulse.
//               Optional build macro ATM_DAILY_LIMIT_EN adds a per-session
//               cumulative withdraw ceiling (DAILY_LIMIT).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module atm_transaction_ctrl
    import atm_pkg::*;
#(
    parameter int BALANCE_WIDTH  = 20,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_WITHDRAW   = 5000
`ifdef ATM_DAILY_LIMIT_EN
    ,
    parameter int DAILY_LIMIT    = 10000
`endif
) (
    input  wire                   clk,
    input  wire                   rst,
    atm_transaction_ctrl_if.slave bus
);

    localparam int                       c_att_w        = (MAX_ATTEMPTS > 1) ? $clog2(MAX_ATTEMPTS) : 1;
    localparam logic [c_att_w:0]         c_max_attempts = (c_att_w + 1)'(MAX_ATTEMPTS);
    localparam logic [BALANCE_WIDTH-1:0] c_max_withdraw = BALANCE_WIDTH'(MAX_WITHDRAW);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [c_att_w-1:0]       r_attempts;
    logic [c_att_w:0]         w_attempts_inc;
    logic [1:0]               r_op_code;
    logic [BALANCE_WIDTH-1:0] r_amount;
    logic [BALANCE_WIDTH-1:0] r_updated_balance;
    logic [BALANCE_WIDTH-1:0] r_shown_balance;
    logic                     r_card_retained;

    logic                     w_result_valid;
    logic [2:0]               w_result_code;
    logic                     w_accept_op;
    logic                     w_timer_kick;
    logic                     w_timer_clear;
    logic                     w_timer_enable;
    logic                     w_timer_expired;
    logic                     w_clr_session;
    logic                     w_inc_attempts;
    logic                     w_set_retained;
    logic                     w_load_result;
    logic                     w_load_shown;
    logic [BALANCE_WIDTH-1:0] w_shown_value;
    logic [BALANCE_WIDTH:0]   w_dep_sum;
    logic [BALANCE_WIDTH-1:0] w_wd_diff;
    logic                     w_daily_over;

    assign w_attempts_inc = {1'b0, r_attempts} + 1'b1;
    assign w_dep_sum      = {1'b0, bus.balance} + {1'b0, r_amount};
    assign w_wd_diff      = bus.balance - r_amount;
    assign w_accept_op    = bus.op_valid && bus.op_ready;

`ifdef ATM_DAILY_LIMIT_EN
    localparam logic [BALANCE_WIDTH+1:0] c_daily_limit = (BALANCE_WIDTH + 2)'(DAILY_LIMIT);

    logic [BALANCE_WIDTH:0]   r_accum;
    logic [BALANCE_WIDTH+1:0] w_accum_sum;

    assign w_accum_sum  = {1'b0, r_accum} + {2'b00, r_amount};
    assign w_daily_over = (w_accum_sum > c_daily_limit);

    // Session withdraw accumulator: restart when a session opens, grow on each committed withdraw
    always_ff @(posedge clk) begin
        if (rst || w_clr_session) begin
            r_accum <= '0;
        end else if ((r_state == S_COMMIT) && (r_op_code == c_op_withdraw)) begin
            r_accum <= r_accum + {1'b0, r_amount};
        end
    end
`else
    assign w_daily_over = 1'b0;
`endif

    // Timer restarts on every state change and on an accepted PIN or op
    assign w_timer_clear  = (w_next_state != r_state) || w_timer_kick;
    assign w_timer_enable = (r_state == S_PIN_WAIT) || (r_state == S_MENU);

    atm_session_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_timer_clear),
        .i_enable  (w_timer_enable),
        .o_expired (w_timer_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic plus the result pulse and datapath load strobes
    always_comb begin
        w_next_state   = r_state;
        w_result_valid = 1'b0;
        w_result_code  = c_res_ok;
        w_timer_kick   = 1'b0;
        w_clr_session  = 1'b0;
        w_inc_attempts = 1'b0;
        w_set_retained = 1'b0;
        w_load_result  = 1'b0;
        w_load_shown   = 1'b0;
        w_shown_value  = r_shown_balance;

        case (r_state)
            S_IDLE: begin
                if (bus.card_inserted) begin
                    w_next_state  = S_PIN_WAIT;
                    w_clr_session = 1'b1;
                end
            end

            S_PIN_WAIT: begin
                // PIN arriving in the expiry cycle beats the timeout
                if (!bus.card_inserted) begin
                    w_next_state = S_IDLE;
                end else if (bus.pin_valid) begin
                    w_next_state = S_PIN_CHECK;
                    w_timer_kick = 1'b1;
                end else if (w_timer_expired) begin
                    w_next_state   = S_EJECT;
                    w_result_valid = 1'b1;
                    w_result_code  = c_res_timeout;
                end
            end

            S_PIN_CHECK: begin
                // wrong_psw is registered upstream, so it is valid one cycle after pin_valid
                if (!bus.card_inserted) begin
                    w_next_state = S_IDLE;
                end else if (!bus.wrong_psw) begin
                    w_next_state = S_MENU;
                end else if (w_attempts_inc < c_max_attempts) begin
                    w_next_state   = S_PIN_WAIT;
                    w_inc_attempts = 1'b1;
                    w_result_valid = 1'b1;
                    w_result_code  = c_res_bad_pin;
                end else begin
                    w_next_state   = S_EJECT;
                    w_set_retained = 1'b1;
                    w_result_valid = 1'b1;
                    w_result_code  = c_res_retained;
                end
            end

            S_MENU: begin
                if (!bus.card_inserted) begin
                    w_next_state = S_IDLE;
                end else if (w_accept_op) begin
                    w_next_state = S_EXEC;
                    w_timer_kick = 1'b1;
                end else if (w_timer_expired) begin
                    w_next_state   = S_EJECT;
                    w_result_valid = 1'b1;
                    w_result_code  = c_res_timeout;
                end
            end

            S_EXEC: begin
                if (!bus.card_inserted) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_MENU;
                    case (r_op_code)
                        c_op_inquiry: begin
                            w_load_shown   = 1'b1;
                            w_shown_value  = bus.balance;
                            w_result_valid = 1'b1;
                            w_result_code  = c_res_ok;
                        end
                        c_op_withdraw: begin
                            // Ceiling checks precede the funds check
                            if ((r_amount == '0) || (r_amount > c_max_withdraw) || w_daily_over) begin
                                w_result_valid = 1'b1;
                                w_result_code  = c_res_limit;
                            end else if (r_amount > bus.balance) begin
                                w_result_valid = 1'b1;
                                w_result_code  = c_res_no_funds;
                            end else begin
                                w_next_state  = S_COMMIT;
                                w_load_result = 1'b1;
                                w_load_shown  = 1'b1;
                                w_shown_value = w_wd_diff;
                            end
                        end
                        c_op_deposit: begin
                            if (r_amount == '0) begin
                                w_result_valid = 1'b1;
                                w_result_code  = c_res_limit;
                            end else if (w_dep_sum[BALANCE_WIDTH]) begin
                                w_result_valid = 1'b1;
                                w_result_code  = c_res_overflow;
                            end else begin
                                w_next_state  = S_COMMIT;
                                w_load_result = 1'b1;
                                w_load_shown  = 1'b1;
                                w_shown_value = w_dep_sum[BALANCE_WIDTH-1:0];
                            end
                        end
                        c_op_exit: begin
                            w_next_state = S_EJECT;
                        end
                    endcase
                end
            end

            S_COMMIT: begin
                // Commit always completes; a pulled card is honoured afterwards
                w_result_valid = 1'b1;
                w_result_code  = c_res_ok;
                w_next_state   = bus.card_inserted ? S_MENU : S_IDLE;
            end

            S_EJECT: begin
                if (!bus.card_inserted) begin
                    w_next_state = S_IDLE;
                end
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Session datapath: attempt count, latched request, balances, retention flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_attempts        <= '0;
            r_op_code         <= '0;
            r_amount          <= '0;
            r_updated_balance <= '0;
            r_shown_balance   <= '0;
            r_card_retained   <= 1'b0;
        end else begin
            if (w_clr_session) begin
                r_attempts <= '0;
            end else if (w_inc_attempts) begin
                r_attempts <= w_attempts_inc[c_att_w-1:0];
            end
            if ((r_state == S_MENU) && bus.card_inserted && w_accept_op) begin
                r_op_code <= bus.op_code;
                r_amount  <= bus.amount;
            end
            if (w_load_result) begin
                r_updated_balance <= w_shown_value;
            end
            if (w_load_shown) begin
                r_shown_balance <= w_shown_value;
            end
            if (w_set_retained) begin
                r_card_retained <= 1'b1;
            end
        end
    end

    assign bus.op_ready        = (r_state == S_MENU) && bus.card_inserted;
    assign bus.op_done         = (r_state == S_COMMIT);
    assign bus.updated_balance = r_updated_balance;
    assign bus.shown_balance   = r_shown_balance;
    assign bus.result_valid    = w_result_valid;
    assign bus.result_code     = w_result_code;
    assign bus.session_active  = is_session_state(r_state);
    assign bus.card_retained   = r_card_retained;

endmodule

`default_nettype wire

// File: tb/tb_atm_transaction_ctrl.sv
// ============================================================================
// Module      : tb_atm_transaction_ctrl
// Description : Self-checking bench for atm_transaction_ctrl. Stimulus tasks
//               queue the expected result/commit events; a monitor pops and
//               compares them whenever the DUT pulses result_valid or op_done.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_atm_transaction_ctrl;

    localparam int BW = 20;

    localparam logic [1:0] OP_INQ = 2'b00;
    localparam logic [1:0] OP_WD  = 2'b01;
    localparam logic [1:0] OP_DEP = 2'b10;
    localparam logic [1:0] OP_EXT = 2'b11;

    localparam logic [2:0] R_OK   = 3'd0;
    localparam logic [2:0] R_BAD  = 3'd1;
    localparam logic [2:0] R_NOF  = 3'd2;
    localparam logic [2:0] R_LIM  = 3'd3;
    localparam logic [2:0] R_OVF  = 3'd4;
    localparam logic [2:0] R_TMO  = 3'd5;
    localparam logic [2:0] R_RET  = 3'd6;

    typedef struct {
        bit            is_done;
        logic [2:0]    code;
        logic [BW-1:0] value;
    } exp_t;

    logic clk;
    logic rst;
    bit   mon_en;
    int   checks;
    int   errors;
    exp_t q[$];

    atm_transaction_ctrl_if #(.BALANCE_WIDTH(BW)) bus ();

    atm_transaction_ctrl #(
        .BALANCE_WIDTH  (BW),
        .MAX_ATTEMPTS   (3),
        .TIMEOUT_CYCLES (64),
        .MAX_WITHDRAW   (5000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every commit/result pulse must match the head of the queue
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.op_done === 1'b1) begin
                checks++;
                if ((q.size() == 0) || !q[0].is_done) begin
                    errors++;
                    $display("FAIL op_done unexpected actual_upd=%0h", bus.updated_balance);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (bus.updated_balance !== e.value) begin
                        errors++;
                        $display("FAIL updated_balance actual=%0h required=%0h", bus.updated_balance, e.value);
                    end
                end
            end
            if (bus.result_valid === 1'b1) begin
                checks++;
                if ((q.size() == 0) || q[0].is_done) begin
                    errors++;
                    $display("FAIL result unexpected actual_code=%0d", bus.result_code);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (bus.result_code !== e.code) begin
                        errors++;
                        $display("FAIL result_code actual=%0d required=%0d", bus.result_code, e.code);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_res(input logic [2:0] code);
        exp_t e;
        e.is_done = 1'b0;
        e.code    = code;
        e.value   = '0;
        q.push_back(e);
    endtask

    task automatic push_done(input logic [BW-1:0] value);
        exp_t e;
        e.is_done = 1'b1;
        e.code    = R_OK;
        e.value   = value;
        q.push_back(e);
    endtask

    // IDLE -> PIN_WAIT
    task automatic insert_card();
        bus.card_inserted = 1'b1;
        tick(1);
    endtask

    // PIN_WAIT -> PIN_CHECK -> (MENU | PIN_WAIT | EJECT)
    task automatic enter_pin(input bit wrong, input bit has_res, input logic [2:0] code);
        if (has_res) push_res(code);
        bus.pin_valid = 1'b1;
        tick(1);
        bus.pin_valid = 1'b0;
        bus.wrong_psw = wrong;
        tick(1);
        bus.wrong_psw = 1'b0;
    endtask

    // MENU -> EXEC -> (MENU | COMMIT -> MENU | EJECT)
    task automatic do_op(input logic [1:0] code, input logic [BW-1:0] amt, input logic [BW-1:0] bal,
                         input bit commit, input logic [BW-1:0] req_val, input logic [2:0] req_code);
        if (commit) begin
            push_done(req_val);
            push_res(R_OK);
        end else if (code != OP_EXT) begin
            push_res(req_code);
        end
        bus.op_valid    = 1'b1;
        bus.op_code     = code;
        bus.amount      = amt;
        bus.balance     = bal;
        tick(1);
        bus.op_valid    = 1'b0;
        tick(1);
        if (commit) tick(1);
    endtask

    task automatic remove_card();
        bus.card_inserted = 1'b0;
        tick(1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        rst    = 1'b1;
        bus.card_inserted = 1'b0;
        bus.pin_valid     = 1'b0;
        bus.op_valid      = 1'b0;
        bus.op_code       = 2'b00;
        bus.amount        = '0;
        bus.balance       = '0;
        bus.wrong_psw     = 1'b0;
        tick(3);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Reset state
        check("rst_op_ready",       32'(bus.op_ready),        32'd0);
        check("rst_op_done",        32'(bus.op_done),         32'd0);
        check("rst_session_active", 32'(bus.session_active),  32'd0);
        check("rst_card_retained",  32'(bus.card_retained),   32'd0);
        check("rst_updated_bal",    32'(bus.updated_balance), 32'd0);
        check("rst_shown_bal",      32'(bus.shown_balance),   32'd0);

        // Good PIN session with a mix of operations
        insert_card();
        check("pinwait_active", 32'(bus.session_active), 32'd1);
        check("pinwait_ready",  32'(bus.op_ready),       32'd0);
        enter_pin(1'b0, 1'b0, R_OK);
        check("menu_ready", 32'(bus.op_ready), 32'd1);

        do_op(OP_WD,  20'd300,   20'd1000,  1'b1, 20'd700,   R_OK);
        check("wd300_shown", 32'(bus.shown_balance), 32'd700);
        do_op(OP_INQ, 20'd0,     20'd1234,  1'b0, 20'd0,     R_OK);
        check("inq_shown", 32'(bus.shown_balance), 32'd1234);
        do_op(OP_WD,  20'd1500,  20'd1000,  1'b0, 20'd0,     R_NOF);
        check("nofunds_upd_held", 32'(bus.updated_balance), 32'd700);
        do_op(OP_WD,  20'd6000,  20'd50000, 1'b0, 20'd0,     R_LIM);
        do_op(OP_WD,  20'd0,     20'd1000,  1'b0, 20'd0,     R_LIM);
        do_op(OP_WD,  20'd5001,  20'd50000, 1'b0, 20'd0,     R_LIM);
        do_op(OP_WD,  20'd5000,  20'd5000,  1'b1, 20'd0,     R_OK);
        do_op(OP_DEP, 20'd2,     20'hFFFFE, 1'b0, 20'd0,     R_OVF);
        check("overflow_upd_held", 32'(bus.updated_balance), 32'd0);
        do_op(OP_DEP, 20'd1,     20'hFFFFE, 1'b1, 20'hFFFFF, R_OK);
        do_op(OP_DEP, 20'd0,     20'd10,    1'b0, 20'd0,     R_LIM);
        do_op(OP_EXT, 20'd0,     20'd10,    1'b0, 20'd0,     R_OK);
        check("exit_eject_active", 32'(bus.session_active), 32'd0);
        tick(2);
        check("eject_hold_active", 32'(bus.session_active), 32'd0);
        remove_card();

        // Three wrong PINs retain the card
        insert_card();
        enter_pin(1'b1, 1'b1, R_BAD);
        check("bad1_active", 32'(bus.session_active), 32'd1);
        enter_pin(1'b1, 1'b1, R_BAD);
        enter_pin(1'b1, 1'b1, R_RET);
        check("retained_flag", 32'(bus.card_retained), 32'd1);
        tick(3);
        check("retained_eject_hold", 32'(bus.session_active), 32'd0);
        remove_card();
        check("retained_sticky", 32'(bus.card_retained), 32'd1);

        // Attempt count restarts with a new session; then idle out of the menu
        insert_card();
        enter_pin(1'b1, 1'b1, R_BAD);
        enter_pin(1'b0, 1'b0, R_OK);
        push_res(R_TMO);
        tick(63);
        check("menu_before_timeout", 32'(bus.op_ready), 32'd1);
        tick(1);
        check("timeout_ready", 32'(bus.op_ready),       32'd0);
        check("timeout_active", 32'(bus.session_active), 32'd0);
        remove_card();

`ifdef ATM_DAILY_LIMIT_EN
        insert_card();
        enter_pin(1'b0, 1'b0, R_OK);
        do_op(OP_WD, 20'd5000, 20'd50000, 1'b1, 20'd45000, R_OK);
        do_op(OP_WD, 20'd5000, 20'd50000, 1'b1, 20'd45000, R_OK);
        do_op(OP_WD, 20'd1,    20'd50000, 1'b0, 20'd0,     R_LIM);
        remove_card();
`endif

        // Card pulled in the menu: straight to IDLE, no result
        insert_card();
        enter_pin(1'b0, 1'b0, R_OK);
        remove_card();
        check("pull_active", 32'(bus.session_active), 32'd0);

        // Reset while the commit cycle is on the bus
        insert_card();
        enter_pin(1'b0, 1'b0, R_OK);
        push_done(20'd900);
        push_res(R_OK);
        bus.op_valid = 1'b1;
        bus.op_code  = OP_WD;
        bus.amount   = 20'd100;
        bus.balance  = 20'd1000;
        tick(1);
        bus.op_valid = 1'b0;
        tick(1);
        check("commit_op_done", 32'(bus.op_done), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rstc_op_done",   32'(bus.op_done),         32'd0);
        check("rstc_upd",       32'(bus.updated_balance), 32'd0);
        check("rstc_shown",     32'(bus.shown_balance),   32'd0);
        check("rstc_retained",  32'(bus.card_retained),   32'd0);
        check("rstc_active",    32'(bus.session_active),  32'd0);
        check("rstc_result",    32'(bus.result_valid),    32'd0);
        bus.card_inserted = 1'b0;
        tick(3);

        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
